// File: rtl/wino_tile_scheduler_if.sv
// Pixel-source, line-buffer bank and tile-flag signals of the Winograd tile scheduler.
// master = pixel source / bank array / transform side, slave = scheduler.
interface wino_tile_scheduler_if #(
  parameter int DW = 8,
  parameter int AW = 10,
  parameter int RW = 9
);
  logic          start;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic [3:0]    wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    bank_map;
  logic          col_valid;
  logic          tile_valid;
  logic [RW-1:0] tile_row;
  logic [AW-1:0] tile_col;
  logic          busy;
  logic          done;

  modport master (
    output start, pix_valid, pix_data,
    input  pix_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, bank_map,
           col_valid, tile_valid, tile_row, tile_col, busy, done
  );

  modport slave (
    input  start, pix_valid, pix_data,
    output pix_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, bank_map,
           col_valid, tile_valid, tile_row, tile_col, busy, done
  );
endinterface

// File: rtl/wino_tile_scheduler.sv
// Four-bank line-buffer sequencer for Winograd F(2x2,3x3): row-steered writes, stride-2 column reads.
// Writes are combinational from accept; tile flags follow rd_en by 1 cycle; pix_ready drops before an unread location.
module wino_tile_scheduler #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 360,
  parameter int DW    = 8,
  parameter int AW    = 10,
  parameter int RW    = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  wino_tile_scheduler_if.slave  bus
);
  localparam int RRW = RW + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  wr_col, rd_col;
  logic [RRW-1:0] wr_row, row_lim;
  logic [RW-1:0]  k;
  logic           accept, rd_last, frame_last, tile_hit;
  logic           col_valid_q, tile_valid_q;
  logic [RW-1:0]  tile_row_q;
  logic [AW-1:0]  tile_col_q;

  // row_lim = 2k+4: first row that lands on a bank still holding tile row k
  assign row_lim    = {1'b0, k, 1'b0} + RRW'(4);
  assign rd_last    = (rd_col == AW'(IMG_W - 1));
  assign frame_last = (k == RW'(IMG_H / 2 - 2));
  assign tile_hit   = (state == S_READ) && rd_col[0] && (rd_col >= AW'(3));

  always_comb begin
    bus.pix_ready = 1'b0;
    if ((state == S_WAIT || state == S_READ) && (wr_row < RRW'(IMG_H))) begin
      if (wr_row < row_lim)
        bus.pix_ready = 1'b1;
      else if ((wr_row == row_lim || wr_row == row_lim + RRW'(1)) &&
               (state == S_READ) && (rd_col > wr_col))
        bus.pix_ready = 1'b1;
    end
  end

  assign accept      = bus.pix_valid & bus.pix_ready;
  assign bus.wr_en   = accept ? (4'b0001 << wr_row[1:0]) : 4'b0000;
  assign bus.wr_addr = wr_col;
  assign bus.wr_data = accept ? bus.pix_data : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_WAIT;
      S_WAIT:  if (wr_row >= row_lim) state_nxt = S_READ;
      S_READ:  if (rd_last) state_nxt = frame_last ? S_DONE : S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col <= '0;
      wr_row <= '0;
      rd_col <= '0;
      k      <= '0;
    end else if (state == S_IDLE) begin
      if (bus.start) begin
        wr_col <= '0;
        wr_row <= '0;
        rd_col <= '0;
        k      <= '0;
      end
    end else begin
      if (accept) begin
        if (wr_col == AW'(IMG_W - 1)) begin
          wr_col <= '0;
          wr_row <= wr_row + RRW'(1);
        end else begin
          wr_col <= wr_col + AW'(1);
        end
      end
      if (state == S_READ) begin
        if (rd_last) begin
          rd_col <= '0;
          if (!frame_last) k <= k + RW'(1);
        end else begin
          rd_col <= rd_col + AW'(1);
        end
      end
    end
  end

  // Bank data appears one cycle after rd_en, so tile flags are registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      col_valid_q  <= 1'b0;
      tile_valid_q <= 1'b0;
      tile_row_q   <= '0;
      tile_col_q   <= '0;
    end else begin
      col_valid_q  <= (state == S_READ);
      tile_valid_q <= tile_hit;
      tile_row_q   <= tile_hit ? k : '0;
      tile_col_q   <= tile_hit ? ((rd_col - AW'(3)) >> 1) : '0;
    end
  end

  assign bus.rd_en      = (state == S_READ);
  assign bus.rd_addr    = rd_col;
  assign bus.bank_map   = k[0] ? 8'h4E : 8'hE4;
  assign bus.col_valid  = col_valid_q;
  assign bus.tile_valid = tile_valid_q;
  assign bus.tile_row   = tile_row_q;
  assign bus.tile_col   = tile_col_q;
  assign bus.busy       = (state == S_WAIT) || (state == S_READ);
  assign bus.done       = (state == S_DONE);
endmodule
